// File: rtl/data_mem_bridge.sv
// data_mem_bridge: CPU data port to word-addressed req/gnt/rvalid memory bus.
// Stalls the CPU until the access completes. Loads return lane-extracted data,
// sign- or zero-extended. Stores are lane-replicated and carry byte enables.
// Build option MISALIGN_TRAP_EN: when defined, misaligned half/word accesses
// are trapped with cpu_err. When undefined, the address is forced to natural
// alignment and the access proceeds normally.
module data_mem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [2:0]  cpu_memop,
    input  logic        cpu_we,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        cpu_err,
    output logic        mem_req,
    output logic [29:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

    state_t      state, state_next;
    logic [31:0] addr_al;
    logic        memop_ok;
    logic        trap;
    logic        timeout_hit;
    logic        done_err;
    logic        done_load;
    logic [31:0] tmo_cnt;
    logic [29:0] addr_q;
    logic [1:0]  off_q;
    logic [2:0]  memop_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        err_q;

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] wd;
        case (size)
            SZ_BYTE: wd = {4{wdata[7:0]}};
            SZ_HALF: wd = {2{wdata[15:0]}};
            default: wd = wdata;
        endcase
        return wd;
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] memop, input logic [1:0] off,
                                            input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (memop)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    // Decode the incoming request: legality, alignment fixup and trap condition
    always_comb begin
        memop_ok = (cpu_memop == 3'b000) || (cpu_memop == 3'b001) || (cpu_memop == 3'b010) ||
                   (cpu_memop == 3'b100) || (cpu_memop == 3'b101);
        addr_al = cpu_addr;
        if (cpu_memop[1:0] == SZ_HALF) begin
            addr_al[0] = 1'b0;
        end else if (cpu_memop[1:0] == SZ_WORD) begin
            addr_al[1:0] = 2'b00;
        end
`ifdef MISALIGN_TRAP_EN
        trap = ((cpu_memop[1:0] == SZ_HALF) && cpu_addr[0]) ||
               ((cpu_memop[1:0] == SZ_WORD) && (cpu_addr[1:0] != 2'b00));
`else
        trap = 1'b0;
`endif
    end

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((tmo_cnt + 32'd1) >= TIMEOUT_CYCLES);

    // Next-state logic; completion beats timeout, timeout beats a bare grant
    always_comb begin
        state_next = state;
        done_err   = 1'b0;
        done_load  = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    if (!memop_ok || trap) begin
                        state_next = DONE;
                        done_err   = 1'b1;
                    end else begin
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_gnt && mem_rvalid) begin
                    state_next = DONE;
                    done_load  = !we_q;
                end else if (timeout_hit) begin
                    state_next = DONE;
                    done_err   = 1'b1;
                end else if (mem_gnt) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_next = DONE;
                    done_load  = !we_q;
                end else if (timeout_hit) begin
                    state_next = DONE;
                    done_err   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Timeout counter: runs while the bus access is outstanding
    always_ff @(posedge clock) begin
        if (reset || !(state == REQ || state == WAIT)) tmo_cnt <= 32'd0;
        else                                           tmo_cnt <= tmo_cnt + 32'd1;
    end

    // Capture the request in IDLE so bus fields stay stable through REQ
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q  <= 30'd0;
            off_q   <= 2'd0;
            memop_q <= 3'd0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
        end else if (state == IDLE && cpu_req) begin
            addr_q  <= addr_al[31:2];
            off_q   <= addr_al[1:0];
            memop_q <= cpu_memop;
            we_q    <= cpu_we;
            be_q    <= lane_be(cpu_memop[1:0], addr_al[1:0]);
            wdata_q <= lane_wdata(cpu_memop[1:0], cpu_wdata);
        end
    end

    // Response register: loaded on entry to DONE, held otherwise
    always_ff @(posedge clock) begin
        if (reset) begin
            err_q     <= 1'b0;
            cpu_rdata <= 32'd0;
        end else if (state != DONE && state_next == DONE) begin
            err_q     <= done_err;
            cpu_rdata <= done_load ? extract(memop_q, off_q, mem_rdata) : 32'd0;
        end
    end

    assign cpu_stall = cpu_req && (state != DONE) && !reset;
    assign cpu_err   = (state == DONE) && err_q;
    assign mem_req   = (state == REQ);
    assign mem_addr  = addr_q;
    assign mem_we    = we_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
// tb_data_mem_bridge: directed accesses against a transaction-level model of
// the bridge; a negedge compare process checks every cycle, and literal
// expectations from hand calculation pin the model.
module tb_data_mem_bridge;

    localparam int TMO = 6;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [2:0]  cpu_memop;
    logic        cpu_we;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        cpu_err;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    logic        chk_on = 1'b0;
    logic        exp_stall, exp_req, exp_we, exp_err;
    logic [29:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_rdata;
    logic [31:0] last_rdata = 32'd0;

    logic [29:0] obs_addr;
    logic [3:0]  obs_be;
    logic [31:0] obs_wdata;
    logic        obs_we;
    logic        obs_req_seen;
    int          obs_done_cycle;

    always #5 clock = ~clock;

    data_mem_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_memop(cpu_memop), .cpu_we(cpu_we),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_err(cpu_err),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (chk_on) begin
            chk("cpu_stall", 32'(cpu_stall), 32'(exp_stall));
            chk("mem_req",   32'(mem_req),   32'(exp_req));
            chk("cpu_err",   32'(cpu_err),   32'(exp_err));
            chk("cpu_rdata", cpu_rdata,      exp_rdata);
            if (exp_req) begin
                chk("mem_addr",  32'(mem_addr), 32'(exp_addr));
                chk("mem_be",    32'(mem_be),   32'(exp_be));
                chk("mem_we",    32'(mem_we),   32'(exp_we));
                chk("mem_wdata", mem_wdata,     exp_wdata);
            end
        end
    end

    task automatic idle_cycle();
        @(posedge clock); #1;
        cpu_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_err = 1'b0; exp_rdata = last_rdata;
    endtask

    // One CPU access. gdly: REQ cycles before gnt (-1 never); rdly: cycles from
    // gnt to rvalid (0 same cycle, -1 never). Leaves the bench in the DONE cycle.
    task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] op,
                          input logic we, input int gdly, input int rdly, input logic [31:0] rd);
        logic        legal, trap, granted, gnt, rv, done, derr;
        logic [1:0]  sz, off;
        logic [31:0] aa, sh, lval;
        int          v, c, gcyc;
        sz    = op[1:0];
        legal = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd5);
`ifdef MISALIGN_TRAP_EN
        trap = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
`else
        trap = 1'b0;
`endif
        aa = a;
        if (sz == 2'd1) aa[0] = 1'b0;
        if (sz == 2'd2) aa[1:0] = 2'd0;
        off = aa[1:0];
        sh  = rd >> (8 * off);
        if (sz == 2'd0) begin
            v = int'(sh & 32'hFF);
            if (!op[2] && v >= 128) v -= 256;
        end else if (sz == 2'd1) begin
            v = int'(sh & 32'hFFFF);
            if (!op[2] && v >= 32768) v -= 65536;
        end else begin
            v = int'(rd);
        end
        lval = 32'(v);
        obs_req_seen = 1'b0;

        @(posedge clock); #1;
        cpu_req = 1'b1; cpu_addr = a; cpu_wdata = wd; cpu_memop = op; cpu_we = we;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = rd;
        exp_stall = 1'b1; exp_req = 1'b0; exp_err = 1'b0; exp_rdata = last_rdata;
        exp_addr = aa[31:2]; exp_we = we;
        case (sz)
            2'd0:    begin exp_be = 4'b0001 << off; exp_wdata = {4{wd[7:0]}};  end
            2'd1:    begin exp_be = 4'b0011 << off; exp_wdata = {2{wd[15:0]}}; end
            default: begin exp_be = 4'b1111;        exp_wdata = wd;            end
        endcase

        done = !legal || trap; derr = done; granted = 1'b0; c = 0; gcyc = 0;
        while (!done) begin
            c++;
            @(posedge clock); #1;
            if (!granted) begin
                exp_req = 1'b1;
                gnt = (gdly >= 0) && (c - 1 == gdly);
                rv  = gnt && (rdly == 0);
            end else begin
                exp_req = 1'b0;
                gnt = 1'b0;
                rv  = (rdly > 0) && (c == gcyc + rdly);
            end
            mem_gnt = gnt; mem_rvalid = rv;
            if (c == 1) begin
                obs_addr = mem_addr; obs_be = mem_be; obs_wdata = mem_wdata; obs_we = mem_we;
            end
            obs_req_seen = obs_req_seen | mem_req;
            if (rv) done = 1'b1;
            else if (c == TMO) begin done = 1'b1; derr = 1'b1; end
            else if (gnt) begin granted = 1'b1; gcyc = c; end
        end

        @(posedge clock); #1;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        obs_req_seen = obs_req_seen | mem_req;
        obs_done_cycle = c + 1;
        exp_stall = 1'b0; exp_req = 1'b0; exp_err = derr;
        last_rdata = (derr || we) ? 32'd0 : lval;
        exp_rdata = last_rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0; cpu_memop = 3'd0;
        cpu_we = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_err = 1'b0; exp_rdata = 32'd0;
        exp_addr = 30'd0; exp_be = 4'd0; exp_we = 1'b0; exp_wdata = 32'd0;
        @(posedge clock); #1;
        chk_on = 1'b1;
        @(negedge clock);
        chk("reset_mem_addr",  32'(mem_addr), 32'd0);
        chk("reset_mem_be",    32'(mem_be),   32'd0);
        chk("reset_mem_wdata", mem_wdata,     32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // lw, minimum latency
        access(32'h0000_0104, 32'd0, 3'b010, 1'b0, 0, 0, 32'hDEAD_BEEF);
        @(negedge clock);
        chk("lw_addr",  32'(obs_addr), 32'h41);
        chk("lw_be",    32'(obs_be),   32'hF);
        chk("lw_rdata", cpu_rdata,     32'hDEAD_BEEF);
        chk("lw_lat",   32'(obs_done_cycle), 32'd2);

        // lb / lbu back to back at byte lane 3
        access(32'h0000_0203, 32'd0, 3'b000, 1'b0, 0, 0, 32'h8012_3456);
        @(negedge clock);
        chk("lb_be",    32'(obs_be), 32'h8);
        chk("lb_rdata", cpu_rdata,   32'hFFFF_FF80);
        access(32'h0000_0203, 32'd0, 3'b100, 1'b0, 1, 1, 32'h8012_3456);
        @(negedge clock);
        chk("lbu_rdata", cpu_rdata, 32'h0000_0080);

        // sh with delayed grant
        access(32'h0000_0102, 32'h1234_ABCD, 3'b001, 1'b1, 3, 1, 32'd0);
        @(negedge clock);
        chk("sh_be",    32'(obs_be),    32'hC);
        chk("sh_wdata", obs_wdata,      32'hABCD_ABCD);
        chk("sh_we",    32'(obs_we),    32'd1);
        chk("sh_rdata", cpu_rdata,      32'd0);

        // sb at lane 1
        access(32'h0000_0001, 32'h0000_005A, 3'b000, 1'b1, 1, 1, 32'd0);
        @(negedge clock);
        chk("sb_be",    32'(obs_be), 32'h2);
        chk("sb_wdata", obs_wdata,   32'h5A5A_5A5A);

        // lh, upper half, sign extension
        access(32'h0000_0206, 32'd0, 3'b001, 1'b0, 0, 2, 32'h8001_7FFF);
        @(negedge clock);
        chk("lh_be",    32'(obs_be), 32'hC);
        chk("lh_rdata", cpu_rdata,   32'hFFFF_8001);

        // misaligned lw
        access(32'h0000_0101, 32'd0, 3'b010, 1'b0, 0, 0, 32'hCAFE_F00D);
        @(negedge clock);
`ifdef MISALIGN_TRAP_EN
        chk("mis_noreq", 32'(obs_req_seen),   32'd0);
        chk("mis_lat",   32'(obs_done_cycle), 32'd1);
        chk("mis_err",   32'(cpu_err),        32'd1);
        chk("mis_rdata", cpu_rdata,           32'd0);
`else
        chk("mis_addr",  32'(obs_addr), 32'h40);
        chk("mis_be",    32'(obs_be),   32'hF);
        chk("mis_err",   32'(cpu_err),  32'd0);
        chk("mis_rdata", cpu_rdata,     32'hCAFE_F00D);
`endif

        // illegal memop
        access(32'h0000_0010, 32'h1111_1111, 3'b011, 1'b1, 0, 0, 32'd0);
        @(negedge clock);
        chk("ill_noreq", 32'(obs_req_seen), 32'd0);
        chk("ill_err",   32'(cpu_err),      32'd1);

        // load a nonzero value, then time out with grant but no response
        access(32'h0000_0300, 32'd0, 3'b010, 1'b0, 0, 0, 32'h1357_9BDF);
        access(32'h0000_0304, 32'd0, 3'b010, 1'b0, 0, -1, 32'd0);
        @(negedge clock);
        chk("tmo_lat",   32'(obs_done_cycle), 32'(TMO + 1));
        chk("tmo_err",   32'(cpu_err),        32'd1);
        chk("tmo_rdata", cpu_rdata,           32'd0);

        // late rvalid in IDLE must be ignored
        idle_cycle();
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        idle_cycle();
        idle_cycle();
        @(negedge clock);
        chk("late_rdata", cpu_rdata,     32'd0);
        chk("late_err",   32'(cpu_err),  32'd0);

        // reset while waiting for the response
        access(32'h0000_0308, 32'd0, 3'b010, 1'b0, 0, 0, 32'h2468_ACE0);
        @(posedge clock); #1;
        cpu_req = 1'b1; cpu_addr = 32'h0000_0400; cpu_memop = 3'b010; cpu_we = 1'b0;
        exp_stall = 1'b1; exp_req = 1'b0; exp_err = 1'b0; exp_rdata = last_rdata;
        exp_addr = 30'h100; exp_be = 4'hF; exp_we = 1'b0; exp_wdata = cpu_wdata;
        @(posedge clock); #1;
        mem_gnt = 1'b1; exp_req = 1'b1;
        @(posedge clock); #1;
        mem_gnt = 1'b0; exp_req = 1'b0; reset = 1'b1; exp_stall = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0; cpu_req = 1'b0; last_rdata = 32'd0; exp_rdata = 32'd0;
        @(negedge clock);
        chk("rst_req",   32'(mem_req),   32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_rdata", cpu_rdata,      32'd0);

        // bridge is back in IDLE: a fresh access completes at minimum latency
        access(32'h0000_0500, 32'd0, 3'b101, 1'b0, 0, 0, 32'h1234_F00D);
        @(negedge clock);
        chk("post_lat",   32'(obs_done_cycle), 32'd2);
        chk("post_rdata", cpu_rdata,           32'h0000_F00D);

        idle_cycle();
        idle_cycle();
        @(negedge clock);
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
